lsu_dcache_arbiter: RTL and testbench
=====================================

# lsu_dcache_arbiter

Single-port D-cache request arbiter and sequencer between the load buffer and the store buffer. It selects one requester per transaction, drives the D-cache request port, tracks the one outstanding access, and routes the response back to its owner. Flushes squash in-flight load data. It sits between the load/store buffers and the D-cache in the execution unit.

## Interface
- ADDR_W, 32, physical address width
- DATA_W, 32, data width; byte-strobe width is DATA_W/8
- STARVE_LIMIT, 4, maximum consecutive load grants while a store waits (used only with the macro below)

- Clk  in  1  clock
- Rest  in  1  reset; synchronous, active-high
- ArbStop  in  1  blocks new grants; in-flight completion continues
- ArbFlash  in  1  pipeline flush
- LbReqAble / LbReqMat / LbReqPtr / LbReqPAddr  in  1/2/3/ADDR_W  load request: valid, MAT, buffer slot, address
- LbReqSuccess  out  1  load request accepted by the D-cache
- LbBackAble / LbBackPtr / LbBackDate  out  1/3/DATA_W  load response: valid, slot, data
- SbReqAble / SbReqMat / SbReqPtr / SbReqPAddr / SbReqDate / SbReqWstrb  in  1/2/3/ADDR_W/DATA_W/DATA_W/8  store request
- SbReqSuccess  out  1  store request accepted
- SbBackAble / SbBackPtr  out  1/3  store completion: valid, slot
- DcdReqAble / DcdReqWrite / DcdReqMat / DcdReqPAddr / DcdReqDate / DcdReqWstrb  out  1/1/2/ADDR_W/DATA_W/DATA_W/8  D-cache request
- DcdReqReady  in  1  D-cache accepts the request this cycle
- DcdRespAble / DcdRespDate  in  1/DATA_W  D-cache response: valid, data
- ArbBusy  out  1  a transaction is outstanding

## Operation
- FSM states: IDLE, LDWAIT, STWAIT. One outstanding transaction at most.
- **Grant in IDLE**, only when ~ArbStop and ~ArbFlash:
  - If both requesters are valid and the word addresses ADDR_W-1:2 match, the store wins. This preserves ordering.
  - Otherwise the load wins.
  - The store wins when no load is valid.
- **Request drive:** DcdReqAble and the request fields come combinationally from the winner. All request fields are 0 when DcdReqAble is 0. DcdReqWrite = 1 for a store.
- **Acceptance:** in the cycle DcdReqAble & DcdReqReady, pulse the winner's ReqSuccess for 1 cycle. In the same cycle, latch the winner's Ptr and type, then go to LDWAIT or STWAIT.
- **Load completion:** in LDWAIT, DcdRespAble drives LbBackAble (unless squashed), LbBackPtr = latched ptr, LbBackDate = DcdRespDate. The FSM returns to IDLE.
- **Store completion:** in STWAIT, DcdRespAble drives SbBackAble and SbBackPtr. The FSM returns to IDLE.
- DcdRespAble is ignored in IDLE.
- **Flush:**
  - In IDLE, no grant is made that cycle.
  - In LDWAIT, a Squash flag is set. The later response is consumed with LbBackAble = 0, and Squash clears on that response.
  - STWAIT is not affected, because committed stores must complete.
- **Priority of controls:** Rest > ArbFlash > ArbStop.
- ArbBusy = (state != IDLE).

## Timing
- **Reset:** state IDLE, Squash 0, starve counter 0, latched ptr 0. All outputs are 0 in the cycle after Rest.
- Request-to-grant latency is 0 cycles (combinational) when DcdReqReady is high. A request is held until Ready.
- Response-to-Back latency is 0 cycles (combinational pass-through).
- The earliest next grant is the cycle after the response. There is no back-to-back grant in the response cycle.
- Rest asserted mid-transaction returns the FSM to IDLE. A stale response that arrives afterwards is ignored.
- ArbFlash and ArbStop asserted together: flush semantics apply.

## Configuration
- LSU_ARB_STARVE_GUARD_EN
- **Defined:**
  - A counter increments on each load grant while SbReqAble is high, saturating at STARVE_LIMIT.
  - It clears on a store grant, or in any cycle where SbReqAble is low.
  - At STARVE_LIMIT the store wins over a valid load.
- **Undefined:** loads always win except on an address match. The counter is not built.

## Structure
- **Shared package:** FSM state encoding (2 bits), a request-type constant (LOAD/STORE), and the word-address compare helper.
- **Sub-module `lsu_arb_age_cnt`:** the saturating starve counter, instantiated only under the macro.

## Test plan
- **Load only:** LbReqAble, PAddr 0x1000, ptr 3, Ready = 1 -> DcdReqAble = 1, DcdReqWrite = 0, and LbReqSuccess pulses the same cycle. Response 0xDEADBEEF 2 cycles later -> LbBackAble = 1, ptr 3, data 0xDEADBEEF; ArbBusy falls the next cycle.
- **Load 0x2000 and store 0x3000 together** -> load granted first. The store is granted in the cycle after the load response.
- **Load 0x4004 and store 0x4006 together** (same word) -> store granted first.
- **Starvation (macro on, STARVE_LIMIT = 4):** store pending, loads continuously valid -> store granted after the 4th load completes. With the macro off, the store waits until loads stop.
- **ArbFlash in LDWAIT, then response** -> LbBackAble stays 0 and the FSM is IDLE next cycle. ArbFlash in STWAIT -> SbBackAble still pulses.
- **Rest mid-STWAIT** -> all outputs 0 next cycle. A later DcdRespAble produces no Back pulse.

Source files
------------

// File: rtl/lsu_dcache_arbiter_pkg.sv
// Shared definitions for the LSU D-cache arbiter: FSM state encoding,
// request-type tag and the word-address compare helper.
package lsu_dcache_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LDWAIT = 2'd1,
      ST_STWAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_LOAD  = 1'b0,
      REQ_STORE = 1'b1
   } req_type_e;

   // Widest physical address the compare helper accepts; callers zero-extend.
   localparam int MAX_ADDR_W = 64;

   // True when two byte addresses fall in the same 32-bit word.
   function automatic logic same_word(input logic [MAX_ADDR_W-1:0] a,
                                      input logic [MAX_ADDR_W-1:0] b);
      return ((a ^ b) >> 2) == '0;
   endfunction

endpackage

// File: rtl/lsu_arb_age_cnt.sv
// Saturating starvation counter for the LSU D-cache arbiter.
// Counts load grants made while a store waits; only instantiated when
// LSU_ARB_STARVE_GUARD_EN is defined.
module lsu_arb_age_cnt #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ld_grant,
   input  logic st_grant,
   input  logic st_pending,
   output logic starved
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // Count load grants while a store is pending; clear once the store is served or leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (st_grant || !st_pending) begin
         cnt <= '0;
      end else if (ld_grant && (cnt != CW'(LIMIT))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign starved = (cnt == CW'(LIMIT));

endmodule

// File: rtl/lsu_dcache_arbiter.sv
// Single-port D-cache request arbiter between the load and store buffers.
// Grants one requester per transaction, tracks the single outstanding access
// and steers the response back to its owner; a flush squashes load data in flight.
// Optional feature: define LSU_ARB_STARVE_GUARD_EN to bound how many loads may
// overtake a waiting store (STARVE_LIMIT).
module lsu_dcache_arbiter
   import lsu_dcache_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                Clk,
   input  logic                Rest,
   input  logic                ArbStop,
   input  logic                ArbFlash,
   // load buffer request
   input  logic                LbReqAble,
   input  logic [1:0]          LbReqMat,
   input  logic [2:0]          LbReqPtr,
   input  logic [ADDR_W-1:0]   LbReqPAddr,
   output logic                LbReqSuccess,
   // load response
   output logic                LbBackAble,
   output logic [2:0]          LbBackPtr,
   output logic [DATA_W-1:0]   LbBackDate,
   // store buffer request
   input  logic                SbReqAble,
   input  logic [1:0]          SbReqMat,
   input  logic [2:0]          SbReqPtr,
   input  logic [ADDR_W-1:0]   SbReqPAddr,
   input  logic [DATA_W-1:0]   SbReqDate,
   input  logic [DATA_W/8-1:0] SbReqWstrb,
   output logic                SbReqSuccess,
   // store completion
   output logic                SbBackAble,
   output logic [2:0]          SbBackPtr,
   // D-cache request port
   output logic                DcdReqAble,
   output logic                DcdReqWrite,
   output logic [1:0]          DcdReqMat,
   output logic [ADDR_W-1:0]   DcdReqPAddr,
   output logic [DATA_W-1:0]   DcdReqDate,
   output logic [DATA_W/8-1:0] DcdReqWstrb,
   input  logic                DcdReqReady,
   // D-cache response port
   input  logic                DcdRespAble,
   input  logic [DATA_W-1:0]   DcdRespDate,
   output logic                ArbBusy
);

   arb_state_e state;
   logic [2:0] owner_ptr;
   logic       squash;
   logic       busy_q;
   logic       grant_ok;
   logic       accept;
   logic       starve_hit;
   logic       resp_ld;
   req_type_e  winner;

`ifdef LSU_ARB_STARVE_GUARD_EN
   lsu_arb_age_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_age_cnt (
      .clk        (Clk),
      .rst        (Rest),
      .ld_grant   (LbReqSuccess),
      .st_grant   (SbReqSuccess),
      .st_pending (SbReqAble),
      .starved    (starve_hit)
   );
`else
   assign starve_hit = 1'b0;
`endif

   // Pick the winner and drive the D-cache request straight from it.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      DcdReqAble   = 1'b0;
      DcdReqWrite  = 1'b0;
      DcdReqMat    = '0;
      DcdReqPAddr  = '0;
      DcdReqDate   = '0;
      DcdReqWstrb  = '0;
      grant_ok     = (state == ST_IDLE) && !Rest && !ArbFlash && !ArbStop;
      // A store to the same word as a waiting load goes first to keep memory order.
      winner       = (SbReqAble && (!LbReqAble || starve_hit ||
                      same_word(MAX_ADDR_W'(LbReqPAddr), MAX_ADDR_W'(SbReqPAddr))))
                     ? REQ_STORE : REQ_LOAD;
      if (grant_ok && (LbReqAble || SbReqAble)) begin
         DcdReqAble = 1'b1;
         if (winner == REQ_STORE) begin
            DcdReqWrite = 1'b1;
            DcdReqMat   = SbReqMat;
            DcdReqPAddr = SbReqPAddr;
            DcdReqDate  = SbReqDate;
            DcdReqWstrb = SbReqWstrb;
         end else begin
            DcdReqMat   = LbReqMat;
            DcdReqPAddr = LbReqPAddr;
         end
      end
      accept       = DcdReqAble && DcdReqReady;
      LbReqSuccess = accept && (winner == REQ_LOAD);
      SbReqSuccess = accept && (winner == REQ_STORE);
   end

   // Steer the D-cache response to its owner; squashed or flushed load data is dropped.
   always_comb begin
      resp_ld    = (state == ST_LDWAIT) && DcdRespAble && !Rest;
      LbBackAble = resp_ld && !squash && !ArbFlash;
      LbBackPtr  = LbBackAble ? owner_ptr : '0;
      LbBackDate = LbBackAble ? DcdRespDate : '0;
      SbBackAble = (state == ST_STWAIT) && DcdRespAble && !Rest;
      SbBackPtr  = SbBackAble ? owner_ptr : '0;
   end

   // Transaction sequencer: latch the owner on acceptance, release on its response.
   always_ff @(posedge Clk) begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      if (Rest) begin
         state     <= ST_IDLE;
         owner_ptr <= '0;
         squash    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  owner_ptr <= (winner == REQ_STORE) ? SbReqPtr : LbReqPtr;
                  state     <= (winner == REQ_STORE) ? ST_STWAIT : ST_LDWAIT;
                  busy_q    <= 1'b1;
               end
            end
            ST_LDWAIT: begin
               if (DcdRespAble) begin
                  state  <= ST_IDLE;
                  squash <= 1'b0;
                  busy_q <= 1'b0;
               end else if (ArbFlash) begin
                  squash <= 1'b1;
               end
            end
            ST_STWAIT: begin
               // Committed stores always complete; a flush has no effect here.
               if (DcdRespAble) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               squash <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign ArbBusy = busy_q;

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Self-checking bench for lsu_dcache_arbiter: a directed vector table, hand-written
// flush/reset/starvation sequences, and a randomized run against a transaction-level
// reference model. Starvation expectations follow LSU_ARB_STARVE_GUARD_EN.
module tb_lsu_dcache_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int NV           = 23;

   logic              Clk = 1'b0;
   logic              Rest, ArbStop, ArbFlash;
   logic              LbReqAble;
   logic [1:0]        LbReqMat;
   logic [2:0]        LbReqPtr;
   logic [31:0]       LbReqPAddr;
   logic              LbReqSuccess, LbBackAble;
   logic [2:0]        LbBackPtr;
   logic [31:0]       LbBackDate;
   logic              SbReqAble;
   logic [1:0]        SbReqMat;
   logic [2:0]        SbReqPtr;
   logic [31:0]       SbReqPAddr, SbReqDate;
   logic [3:0]        SbReqWstrb;
   logic              SbReqSuccess, SbBackAble;
   logic [2:0]        SbBackPtr;
   logic              DcdReqAble, DcdReqWrite;
   logic [1:0]        DcdReqMat;
   logic [31:0]       DcdReqPAddr, DcdReqDate;
   logic [3:0]        DcdReqWstrb;
   logic              DcdReqReady, DcdRespAble;
   logic [31:0]       DcdRespDate;
   logic              ArbBusy;

   wire [71:0] req_bus  = {DcdReqAble, DcdReqWrite, DcdReqMat, DcdReqPAddr, DcdReqDate, DcdReqWstrb};
   wire [42:0] back_bus = {LbReqSuccess, SbReqSuccess, LbBackAble, LbBackPtr, LbBackDate,
                           SbBackAble, SbBackPtr, ArbBusy};

   always #5 Clk = ~Clk;

   lsu_dcache_arbiter #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W), .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .Clk (Clk), .Rest (Rest), .ArbStop (ArbStop), .ArbFlash (ArbFlash),
      .LbReqAble (LbReqAble), .LbReqMat (LbReqMat), .LbReqPtr (LbReqPtr),
      .LbReqPAddr (LbReqPAddr), .LbReqSuccess (LbReqSuccess),
      .LbBackAble (LbBackAble), .LbBackPtr (LbBackPtr), .LbBackDate (LbBackDate),
      .SbReqAble (SbReqAble), .SbReqMat (SbReqMat), .SbReqPtr (SbReqPtr),
      .SbReqPAddr (SbReqPAddr), .SbReqDate (SbReqDate), .SbReqWstrb (SbReqWstrb),
      .SbReqSuccess (SbReqSuccess), .SbBackAble (SbBackAble), .SbBackPtr (SbBackPtr),
      .DcdReqAble (DcdReqAble), .DcdReqWrite (DcdReqWrite), .DcdReqMat (DcdReqMat),
      .DcdReqPAddr (DcdReqPAddr), .DcdReqDate (DcdReqDate), .DcdReqWstrb (DcdReqWstrb),
      .DcdReqReady (DcdReqReady), .DcdRespAble (DcdRespAble), .DcdRespDate (DcdRespDate),
      .ArbBusy (ArbBusy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Side fields are derived from ptr/address so every request carries distinct content.
   task automatic drive(input logic rest, stop, flash, lb_v, input logic [31:0] lb_a,
                        input logic [2:0] lb_p, input logic sb_v, input logic [31:0] sb_a,
                        input logic [2:0] sb_p, input logic rdy, rv, input logic [31:0] rd);
      Rest        = rest;
      ArbStop     = stop;
      ArbFlash    = flash;
      LbReqAble   = lb_v;
      LbReqPAddr  = lb_a;
      LbReqPtr    = lb_p;
      LbReqMat    = lb_p[1:0];
      SbReqAble   = sb_v;
      SbReqPAddr  = sb_a;
      SbReqPtr    = sb_p;
      SbReqMat    = sb_p[2:1];
      SbReqDate   = sb_a ^ 32'h5A5A_5A5A;
      SbReqWstrb  = sb_a[3:0] | 4'h1;
      DcdReqReady = rdy;
      DcdRespAble = rv;
      DcdRespDate = rd;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_dut();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   typedef struct {
      logic        rest, stop, flash;
      logic        lb_v;
      logic [31:0] lb_a;
      logic [2:0]  lb_p;
      logic        sb_v;
      logic [31:0] sb_a;
      logic [2:0]  sb_p;
      logic        rdy, rv;
      logic [31:0] rd;
      logic        e_req, e_wr;
      logic [31:0] e_addr;
      logic        e_lsucc, e_ssucc, e_lback;
      logic [2:0]  e_lptr;
      logic [31:0] e_ldata;
      logic        e_sback;
      logic [2:0]  e_sptr;
      logic        e_busy;
   } vec_t;

   vec_t tv [NV];

   task automatic apply(input vec_t v, input int idx);
      drive(v.rest, v.stop, v.flash, v.lb_v, v.lb_a, v.lb_p, v.sb_v, v.sb_a, v.sb_p,
            v.rdy, v.rv, v.rd);
      @(negedge Clk);
      check($sformatf("vec%0d.req", idx),   96'(DcdReqAble),   96'(v.e_req));
      check($sformatf("vec%0d.write", idx), 96'(DcdReqWrite),  96'(v.e_wr));
      check($sformatf("vec%0d.addr", idx),  96'(DcdReqPAddr),  96'(v.e_addr));
      check($sformatf("vec%0d.lsucc", idx), 96'(LbReqSuccess), 96'(v.e_lsucc));
      check($sformatf("vec%0d.ssucc", idx), 96'(SbReqSuccess), 96'(v.e_ssucc));
      check($sformatf("vec%0d.lback", idx), 96'(LbBackAble),   96'(v.e_lback));
      if (v.e_lback) begin
         check($sformatf("vec%0d.lptr", idx),  96'(LbBackPtr),  96'(v.e_lptr));
         check($sformatf("vec%0d.ldata", idx), 96'(LbBackDate), 96'(v.e_ldata));
      end
      check($sformatf("vec%0d.sback", idx), 96'(SbBackAble), 96'(v.e_sback));
      if (v.e_sback)
         check($sformatf("vec%0d.sptr", idx), 96'(SbBackPtr), 96'(v.e_sptr));
      check($sformatf("vec%0d.busy", idx), 96'(ArbBusy), 96'(v.e_busy));
      tick();
   endtask

   // Reference model: a queue of at most one outstanding transaction.
   typedef struct {
      logic       is_store;
      logic [2:0] ptr;
      logic       squashed;
   } txn_t;

   task automatic random_phase(input int n);
      txn_t        pend[$];
      txn_t        t;
      int          starve;
      logic        r_rest, r_stop, r_flash, r_lv, r_sv, r_rdy, r_rv;
      logic [31:0] r_la, r_sa, r_rd;
      logic [2:0]  r_lp, r_sp;
      logic        idle, same, forced, st_first, e_req, e_lback, e_sback, granted;
      logic [71:0] e_bus;
      starve = 0;
      reset_dut();
      for (int i = 0; i < n; i++) begin
         r_rest  = ($urandom_range(0, 39) == 0);
         r_stop  = ($urandom_range(0, 7) == 0);
         r_flash = ($urandom_range(0, 9) == 0);
         r_lv    = ($urandom_range(0, 2) != 0);
         r_sv    = ($urandom_range(0, 1) == 1);
         r_la    = 32'h100 + 32'($urandom_range(0, 7));
         r_sa    = 32'h100 + 32'($urandom_range(0, 7));
         r_lp    = 3'($urandom_range(0, 7));
         r_sp    = 3'($urandom_range(0, 7));
         r_rdy   = ($urandom_range(0, 2) != 0);
         r_rv    = ($urandom_range(0, 2) == 0);
         r_rd    = $urandom;
         drive(r_rest, r_stop, r_flash, r_lv, r_la, r_lp, r_sv, r_sa, r_sp, r_rdy, r_rv, r_rd);
         @(negedge Clk);

         idle = (pend.size() == 0);
         same = r_lv && r_sv && (r_la[31:2] == r_sa[31:2]);
`ifdef LSU_ARB_STARVE_GUARD_EN
         forced = (starve >= STARVE_LIMIT);
`else
         forced = 1'b0;
`endif
         st_first = r_sv && (!r_lv || same || forced);
         e_req    = idle && !r_rest && !r_flash && !r_stop && (r_lv || r_sv);
         e_bus    = '0;
         if (e_req)
            e_bus = st_first ? {1'b1, 1'b1, r_sp[2:1], r_sa, r_sa ^ 32'h5A5A_5A5A, r_sa[3:0] | 4'h1}
                             : {1'b1, 1'b0, r_lp[1:0], r_la, 32'h0, 4'h0};
         e_lback = 1'b0;
         e_sback = 1'b0;
         if (!idle && r_rv && !r_rest) begin
            e_lback = !pend[0].is_store && !pend[0].squashed && !r_flash;
            e_sback = pend[0].is_store;
         end
         granted = e_req && r_rdy;

         check($sformatf("rnd%0d.req_bus", i), 96'(req_bus), 96'(e_bus));
         check($sformatf("rnd%0d.lsucc", i), 96'(LbReqSuccess), 96'(granted && !st_first));
         check($sformatf("rnd%0d.ssucc", i), 96'(SbReqSuccess), 96'(granted && st_first));
         check($sformatf("rnd%0d.lback", i), 96'(LbBackAble), 96'(e_lback));
         if (e_lback)
            check($sformatf("rnd%0d.lback_fields", i), 96'({LbBackPtr, LbBackDate}),
                  96'({pend[0].ptr, r_rd}));
         check($sformatf("rnd%0d.sback", i), 96'(SbBackAble), 96'(e_sback));
         if (e_sback)
            check($sformatf("rnd%0d.sptr", i), 96'(SbBackPtr), 96'(pend[0].ptr));
         check($sformatf("rnd%0d.busy", i), 96'(ArbBusy), 96'(!idle));

         if (r_rest) begin
            pend.delete();
            starve = 0;
         end else begin
            if (!idle) begin
               if (r_rv) begin
                  void'(pend.pop_front());
               end else if (r_flash && !pend[0].is_store) begin
                  t          = pend[0];
                  t.squashed = 1'b1;
                  pend[0]    = t;
               end
            end
            if (granted) begin
               t.is_store = st_first;
               t.ptr      = st_first ? r_sp : r_lp;
               t.squashed = 1'b0;
               pend.push_back(t);
            end
            if (!r_sv || (granted && st_first))
               starve = 0;
            else if (granted && starve < STARVE_LIMIT)
               starve++;
         end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ld;
      logic got_st;

      //           rst stp fls lbv lb_a      lbp sbv sb_a      sbp rdy rv  rd             req wr  addr       ls  ss  lbk lpt ldata          sbk spt busy
      tv[0]  = '{1, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[1]  = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[2]  = '{0, 0, 0, 1, 'h1000,   3, 0, 'h0,      0, 1, 0, 'h0,          1, 0, 'h1000,   1, 0, 0, 0, 'h0,          0, 0, 0};
      tv[3]  = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 1};
      tv[4]  = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 1, 'hDEADBEEF,   0, 0, 'h0,      0, 0, 1, 3, 'hDEADBEEF,   0, 0, 1};
      tv[5]  = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[6]  = '{0, 0, 0, 1, 'h2000,   1, 1, 'h3000,   2, 1, 0, 'h0,          1, 0, 'h2000,   1, 0, 0, 0, 'h0,          0, 0, 0};
      tv[7]  = '{0, 0, 0, 0, 'h0,      0, 1, 'h3000,   2, 1, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 1};
      tv[8]  = '{0, 0, 0, 0, 'h0,      0, 1, 'h3000,   2, 1, 1, 'h1111,       0, 0, 'h0,      0, 0, 1, 1, 'h1111,       0, 0, 1};
      tv[9]  = '{0, 0, 0, 0, 'h0,      0, 1, 'h3000,   2, 1, 0, 'h0,          1, 1, 'h3000,   0, 1, 0, 0, 'h0,          0, 0, 0};
      tv[10] = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 1, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          1, 2, 1};
      tv[11] = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[12] = '{0, 0, 0, 1, 'h4004,   4, 1, 'h4006,   5, 1, 0, 'h0,          1, 1, 'h4006,   0, 1, 0, 0, 'h0,          0, 0, 0};
      tv[13] = '{0, 0, 0, 1, 'h4004,   4, 0, 'h0,      0, 1, 1, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          1, 5, 1};
      tv[14] = '{0, 0, 0, 1, 'h4004,   4, 0, 'h0,      0, 1, 0, 'h0,          1, 0, 'h4004,   1, 0, 0, 0, 'h0,          0, 0, 0};
      tv[15] = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 1, 'hCAFE0004,   0, 0, 'h0,      0, 0, 1, 4, 'hCAFE0004,   0, 0, 1};
      tv[16] = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[17] = '{0, 1, 0, 1, 'h7000,   6, 0, 'h0,      0, 1, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[18] = '{0, 0, 0, 1, 'h7000,   6, 0, 'h0,      0, 0, 0, 'h0,          1, 0, 'h7000,   0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[19] = '{0, 0, 0, 1, 'h7000,   6, 0, 'h0,      0, 1, 0, 'h0,          1, 0, 'h7000,   1, 0, 0, 0, 'h0,          0, 0, 0};
      tv[20] = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 1, 'h77,         0, 0, 'h0,      0, 0, 1, 6, 'h77,         0, 0, 1};
      tv[21] = '{0, 1, 1, 1, 'h7100,   0, 1, 'h7200,   1, 1, 0, 'h0,          0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};
      tv[22] = '{0, 0, 0, 0, 'h0,      0, 0, 'h0,      0, 0, 1, 'h99,         0, 0, 'h0,      0, 0, 0, 0, 'h0,          0, 0, 0};

      reset_dut();
      for (int i = 0; i < NV; i++)
         apply(tv[i], i);

      // Flush while a load is in flight: its response is swallowed, squash then clears.
      reset_dut();
      drive(0, 0, 0, 1, 32'h5000, 3'd6, 0, 0, 0, 1, 0, 0);
      @(negedge Clk); check("ldflush.grant", 96'(LbReqSuccess), 96'(1)); tick();
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk); check("ldflush.flush_cycle", 96'({LbBackAble, ArbBusy}), 96'(2'b01)); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
      @(negedge Clk); check("ldflush.resp_dropped", 96'(LbBackAble), 96'(0)); tick();
      drive_idle();
      @(negedge Clk); check("ldflush.idle_after", 96'(ArbBusy), 96'(0)); tick();
      drive(0, 0, 0, 1, 32'h5004, 3'd2, 0, 0, 0, 1, 0, 0);
      @(negedge Clk); check("ldflush.next_grant", 96'(LbReqSuccess), 96'(1)); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0123_4567);
      @(negedge Clk);
      check("ldflush.next_back", 96'({LbBackAble, LbBackPtr, LbBackDate}), 96'({1'b1, 3'd2, 32'h0123_4567}));
      tick();

      // Flush while a store is in flight: the store still completes.
      drive(0, 0, 0, 0, 0, 0, 1, 32'h6000, 3'd3, 1, 0, 0);
      @(negedge Clk); check("stflush.grant", 96'(SbReqSuccess), 96'(1)); tick();
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk); check("stflush.flush_cycle", 96'({SbBackAble, ArbBusy}), 96'(2'b01)); tick();
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge Clk); check("stflush.back", 96'({SbBackAble, SbBackPtr}), 96'({1'b1, 3'd3})); tick();
      drive_idle();
      @(negedge Clk); check("stflush.idle_after", 96'(ArbBusy), 96'(0)); tick();

      // Reset in the middle of a store: everything clears and a stale response is ignored.
      drive(0, 0, 0, 0, 0, 0, 1, 32'h6100, 3'd4, 1, 0, 0);
      @(negedge Clk); check("rstmid.grant", 96'(SbReqSuccess), 96'(1)); tick();
      drive_idle();
      @(negedge Clk); check("rstmid.busy", 96'(ArbBusy), 96'(1)); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      @(negedge Clk);
      check("rstmid.req_bus", 96'(req_bus), 96'(0));
      check("rstmid.back_bus", 96'(back_bus), 96'(0));
      tick();
      drive_idle();
      @(negedge Clk); check("rstmid.still_idle", 96'(back_bus), 96'(0)); tick();

      // Store waits behind a continuous stream of loads to other words.
      reset_dut();
      n_ld   = 0;
      got_st = 1'b0;
`ifdef LSU_ARB_STARVE_GUARD_EN
      for (int c = 0; c < 40 && !got_st; c++) begin
         drive(0, 0, 0, 1, 32'h9000 + 32'(c * 16), 3'(c), 1, 32'h8000, 3'd7, 1, 1, 32'(c));
         @(negedge Clk);
         if (SbReqSuccess) got_st = 1'b1;
         if (LbReqSuccess) n_ld++;
         tick();
      end
      check("starve.store_granted", 96'(got_st), 96'(1));
      check("starve.loads_before_store", 96'(n_ld), 96'(STARVE_LIMIT));
`else
      for (int c = 0; c < 24; c++) begin
         drive(0, 0, 0, 1, 32'h9000 + 32'(c * 16), 3'(c), 1, 32'h8000, 3'd7, 1, 1, 32'(c));
         @(negedge Clk);
         if (SbReqSuccess) got_st = 1'b1;
         if (LbReqSuccess) n_ld++;
         tick();
      end
      check("starve.store_held", 96'(got_st), 96'(0));
      check("starve.loads_granted", 96'(n_ld), 96'(12));
      for (int c = 0; c < 6 && !got_st; c++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 32'h8000, 3'd7, 1, 1, 0);
         @(negedge Clk);
         if (SbReqSuccess) got_st = 1'b1;
         tick();
      end
      check("starve.store_after_loads", 96'(got_st), 96'(1));
`endif

      random_phase(400);

      drive_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
